// File: rtl/rv_defs.sv
// Shared RISC-V fetch definitions: reset PC, halfword queue geometry, opcode marker.
package rv_defs;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned Q_DEPTH          = 4;
    localparam int unsigned HW_W             = 16;
    localparam int unsigned Q_PTR_W          = $clog2(Q_DEPTH);
    localparam int unsigned Q_CNT_W          = $clog2(Q_DEPTH + 1);
    localparam logic [1:0]  OPC_UNCOMP       = 2'b11;

    typedef logic [HW_W-1:0] halfword_t;

    // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
    function automatic logic is_compressed(input halfword_t hw);
        return hw[1:0] != OPC_UNCOMP;
    endfunction

endpackage

// File: rtl/hw_queue.sv
// Four-entry halfword FIFO; pushes and pops one or two halfwords per cycle.
module hw_queue
    import rv_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic [1:0]         i_push_n,
    input  halfword_t          i_push_lo,
    input  halfword_t          i_push_hi,
    input  logic [1:0]         i_pop_n,
    output halfword_t          o_head0,
    output halfword_t          o_head1,
    output logic [Q_CNT_W-1:0] o_cnt
);

    halfword_t            r_mem [Q_DEPTH];
    logic [Q_PTR_W-1:0]   r_rd_ptr;
    logic [Q_CNT_W-1:0]   r_cnt;
    logic [Q_PTR_W-1:0]   w_wr0;
    logic [Q_PTR_W-1:0]   w_wr1;
    logic [Q_PTR_W-1:0]   w_rd1;

    // Write slots follow the live entries; the caller guarantees room.
    assign w_wr0   = r_rd_ptr + r_cnt[Q_PTR_W-1:0];
    assign w_wr1   = w_wr0 + Q_PTR_W'(1);
    assign w_rd1   = r_rd_ptr + Q_PTR_W'(1);
    assign o_head0 = r_mem[r_rd_ptr];
    assign o_head1 = r_mem[w_rd1];
    assign o_cnt   = r_cnt;

    // Storage, read pointer and occupancy; flush empties without touching data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_push_n != 2'd0) begin
                r_mem[w_wr0] <= i_push_lo;
            end
            if (i_push_n == 2'd2) begin
                r_mem[w_wr1] <= i_push_hi;
            end
            r_rd_ptr <= r_rd_ptr + Q_PTR_W'(i_pop_n);
            r_cnt    <= r_cnt + Q_CNT_W'(i_push_n) - Q_CNT_W'(i_pop_n);
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Fetches 32-bit words and re-aligns them into 16/32-bit RISC-V instructions.
module fetch_aligner
    import rv_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    logic [31:0]        r_inst_pc;
    logic [31:0]        r_mem_addr;
    logic               r_drop_low;
    logic               r_outstanding;
    logic               r_kill;

    halfword_t          w_head0;
    halfword_t          w_head1;
    logic [Q_CNT_W-1:0] w_hw_cnt;
    logic               w_head_c;
    logic               w_valid;
    logic               w_fire;
    logic               w_accept;
    logic [1:0]         w_push_n;
    logic [1:0]         w_pop_n;
    halfword_t          w_push_lo;

    hw_queue u_queue (
        .clk       (clk),
        .rst_n     (rst),
        .i_flush   (redirect),
        .i_push_n  (w_push_n),
        .i_push_lo (w_push_lo),
        .i_push_hi (mem_data[31:16]),
        .i_pop_n   (w_pop_n),
        .o_head0   (w_head0),
        .o_head1   (w_head1),
        .o_cnt     (w_hw_cnt)
    );

    // Head decode and handshake; redirect masks both the offer and the push.
    assign w_head_c  = is_compressed(w_head0);
    assign w_valid   = rst && !redirect &&
                       ((w_hw_cnt >= Q_CNT_W'(2)) || ((w_hw_cnt != '0) && w_head_c));
    assign w_fire    = w_valid && inst_ready;
    assign w_pop_n   = w_fire ? (w_head_c ? 2'd1 : 2'd2) : 2'd0;
    assign w_accept  = rst && !redirect && r_outstanding && !r_kill && mem_valid;
    assign w_push_n  = w_accept ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_lo = r_drop_low ? mem_data[31:16] : mem_data[15:0];

    // New fetch only when idle and a full word is guaranteed to fit.
    assign mem_req    = rst && !redirect && !r_outstanding && (w_hw_cnt <= Q_CNT_W'(2));
    assign mem_addr   = r_mem_addr;
    assign inst_valid = w_valid;
    assign inst_pc    = r_inst_pc;
    assign inst_is_c  = rst && w_head_c;
    assign inst       = !rst     ? 32'h0 :
                        w_head_c ? {16'h0, w_head0} : {w_head1, w_head0};

    // PC, fetch address and request tracking; redirect overrides any handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_pc     <= RESET_PC;
            r_mem_addr    <= {RESET_PC[31:2], 2'b00};
            r_drop_low    <= RESET_PC[1];
            r_outstanding <= 1'b0;
            r_kill        <= 1'b0;
        end else if (redirect) begin
            r_inst_pc     <= redirect_pc;
            r_mem_addr    <= {redirect_pc[31:2], 2'b00};
            r_drop_low    <= redirect_pc[1];
            // A response landing this very cycle retires the request; otherwise it must be killed.
            r_outstanding <= r_outstanding && !mem_valid;
            r_kill        <= r_outstanding && !mem_valid;
        end else begin
            if (w_fire) begin
                r_inst_pc <= r_inst_pc + (w_head_c ? 32'd2 : 32'd4);
            end
            if (w_accept) begin
                r_mem_addr <= r_mem_addr + 32'd4;
                r_drop_low <= 1'b0;
            end
            if (mem_req) begin
                r_outstanding <= 1'b1;
            end else if (mem_valid) begin
                r_outstanding <= 1'b0;
                r_kill        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Scoreboard bench for fetch_aligner: memory responder, reference decoder, monitor.
module tb_fetch_aligner;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int          n_checks;
    int          n_pass;
    int          rsp_delay;
    int          rst_epoch;
    exp_t        exp_q[$];
    logic [31:0] ovr [logic [31:0]];

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_is_c   (inst_is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: explicit overrides, otherwise a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference decoder: walk the program from a start PC and queue n instructions.
    task automatic push_expected(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [15:0] h;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h    = hw_at(pc);
            e.pc = pc;
            if (h[1:0] != 2'b11) begin
                e.inst = {16'h0, h};
                e.is_c = 1'b1;
                pc     = pc + 32'd2;
            end else begin
                e.inst = {hw_at(pc + 32'd2), h};
                e.is_c = 1'b0;
                pc     = pc + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Returns at the negedge of the first cycle presenting mem_req.
    task automatic wait_req(input int bound, output logic ok, output logic [31:0] addr);
        ok   = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (mem_req) begin
                ok   = 1'b1;
                addr = mem_addr;
            end
        end
    endtask

    task automatic start_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        push_expected(pc, 64);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        start_redirect(pc);
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            inst_ready = ($urandom_range(99, 0) < ready_pct);
            @(posedge clk); #1;
        end
    endtask

    // Memory responder: answers each request after rsp_delay cycles; drops it across a reset.
    initial begin
        logic [31:0] a;
        int          ep;
        mem_valid = 1'b0;
        mem_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst && mem_req) begin
                a  = mem_addr;
                ep = rst_epoch;
                repeat (rsp_delay) @(posedge clk);
                #1;
                if (rst && ep == rst_epoch) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_word(a);
                    @(posedge clk); #1;
                    mem_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every offered instruction must match the scoreboard head; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (inst_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL exp_empty: got inst %h at pc %h, required no instruction", inst, inst_pc);
                end else begin
                    e = exp_q[0];
                    check("inst", inst, e.inst);
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_is_c", {31'h0, inst_is_c}, {31'h0, e.is_c});
                    if (inst_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic        ok;
        logic [31:0] a;
        logic [31:0] p;
        int          quiet;

        n_checks    = 0;
        n_pass      = 0;
        rst_epoch   = 0;
        rsp_delay   = 1;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        ovr[32'h0000_0000] = 32'h00A0_0093;
        ovr[32'h0000_0004] = 32'h4501_4505;
        // Upper halfword ends in 2'b11 so the instruction at 0x102 straddles into 0x104.
        ovr[32'h0000_0100] = 32'h1113_2222;
        ovr[32'h0000_0104] = 32'h3333_4444;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_is_c", {31'h0, inst_is_c}, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        // Reset release: 32-bit then two compressed instructions from address 0.
        @(posedge clk); #1;
        exp_q.delete();
        push_expected(32'h0, 64);
        rst        = 1'b1;
        inst_ready = 1'b1;
        wait_req(20, ok, a);
        check("first_req_ok", {31'h0, ok}, 32'h1);
        check("first_req_addr", a, 32'h0);
        @(posedge clk); #1;
        run_cycles(15, 100);

        // Misaligned redirect target: drop the low halfword of the first word.
        inst_ready = 1'b0;
        do_redirect(32'h0000_0102);
        wait_req(20, ok, a);
        check("mis_req0_ok", {31'h0, ok}, 32'h1);
        check("mis_req0_addr", a, 32'h0000_0100);
        @(posedge clk); #1;
        wait_req(20, ok, a);
        check("mis_req1_ok", {31'h0, ok}, 32'h1);
        check("mis_req1_addr", a, 32'h0000_0104);
        @(posedge clk); #1;
        run_cycles(12, 100);

        // Redirect with a slow response outstanding: stale word is discarded.
        rsp_delay  = 3;
        inst_ready = 1'b1;
        do_redirect(32'h0000_0200);
        wait_req(20, ok, a);
        check("kill_req_ok", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
        do_redirect(32'h0000_0300);
        quiet = 0;
        ok    = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mem_req) ok = 1'b1;
            else quiet++;
        end
        check("kill_quiet_cycles", 32'(quiet), 32'd2);
        check("kill_next_addr", mem_addr, 32'h0000_0300);
        @(posedge clk); #1;
        run_cycles(15, 100);

        // Back-pressure: queue fills to 4 and fetching stops.
        rsp_delay  = 1;
        inst_ready = 1'b0;
        do_redirect(32'h0000_0400);
        repeat (6) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_mem_req", {31'h0, mem_req}, 32'h0);
            check("full_hw_cnt", 32'(dut.w_hw_cnt), 32'd4);
            @(posedge clk); #1;
        end

        // Redirect in the same cycle as a ready head: no pop, PC takes the target.
        inst_ready = 1'b1;
        start_redirect(32'h0000_0500);
        @(negedge clk);
        check("redir_inst_valid", {31'h0, inst_valid}, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0;
        check("redir_inst_pc", inst_pc, 32'h0000_0500);
        check("redir_hw_cnt", 32'(dut.w_hw_cnt), 32'd0);
        run_cycles(10, 70);

        // Address wrap at the top of the address space.
        inst_ready = 1'b1;
        do_redirect(32'hFFFF_FFFC);
        wait_req(20, ok, a);
        check("wrap_req0_addr", a, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        wait_req(20, ok, a);
        check("wrap_req1_ok", {31'h0, ok}, 32'h1);
        check("wrap_req1_addr", a, 32'h0000_0000);
        @(posedge clk); #1;
        run_cycles(12, 100);

        // Reset asserted mid-request: the request is abandoned.
        rsp_delay = 3;
        do_redirect(32'h0000_0600);
        wait_req(20, ok, a);
        @(posedge clk); #1;
        rst = 1'b0;
        rst_epoch++;
        exp_q.delete();
        @(negedge clk);
        check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        push_expected(32'h0, 64);
        rst = 1'b1;
        wait_req(20, ok, a);
        check("midrst_req_ok", {31'h0, ok}, 32'h1);
        check("midrst_req_addr", a, 32'h0);
        @(posedge clk); #1;
        run_cycles(12, 100);

        // Randomized segments: random targets, latencies, back-pressure and redirect timing.
        for (int s = 0; s < 20; s++) begin
            rsp_delay = $urandom_range(3, 1);
            p         = $urandom;
            p[0]      = 1'b0;
            if ($urandom_range(3, 0) == 0) p = {16'h0000, p[15:0]};
            do_redirect(p);
            run_cycles($urandom_range(35, 1), $urandom_range(100, 40));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
